// File: rtl/dadda_pkg.sv
// Shared constants, types and helpers for the pipelined 16x16 Dadda reduction tree.
// Column heights are derived at elaboration time so each layer knows its exact shape.
package dadda_pkg;

    localparam int unsigned N           = 16;
    localparam int unsigned OUT_W       = 2 * N;
    localparam int unsigned NUM_LAYERS  = 6;
    localparam int unsigned DADDA_SEQ [NUM_LAYERS] = '{13, 9, 6, 4, 3, 2};
    localparam int unsigned STAGE_SPLIT = 6;

    typedef logic [4:0]         col_h_t;
    typedef col_h_t [OUT_W-1:0] col_vec_t;

    function automatic int unsigned n_fa(input int unsigned tot, input int unsigned d);
        return (tot > d) ? (tot - d) / 2 : 0;
    endfunction

    function automatic int unsigned n_ha(input int unsigned tot, input int unsigned d);
        return (tot > d) ? (tot - d) % 2 : 0;
    endfunction

    function automatic col_vec_t pp_heights();
        col_vec_t h;
        h = '0;
        for (int unsigned k = 0; k < OUT_W; k++) begin
            h[k] = col_h_t'((k < N) ? k + 1 : ((k < OUT_W - 1) ? OUT_W - 1 - k : 0));
        end
        return h;
    endfunction

    // Column heights after one layer; the carry count of column i lands in column i+1.
    function automatic col_vec_t layer_out_h(input col_vec_t h_in, input int unsigned d);
        col_vec_t    r;
        int unsigned cin, tot, fa, ha;
        r   = '0;
        cin = 0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            tot  = 32'(h_in[i]) + cin;
            fa   = n_fa(tot, d);
            ha   = n_ha(tot, d);
            r[i] = col_h_t'(tot - 2 * fa - ha);
            cin  = fa + ha;
        end
        return r;
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/dadda_reduce_pipe_layer.sv
// One Dadda reduction layer: compresses every column to at most D bits with FA/HA cells.
// Output column order is: carries from column i-1, then sums, then pass-through bits.
module dadda_layer
    import dadda_pkg::*;
#(
    parameter col_vec_t    H_IN = '0,
    parameter int unsigned W_IN = 16,
    parameter int unsigned D    = 13
) (
    input  logic [OUT_W-1:0][W_IN-1:0] m_in,
    output logic [OUT_W-1:0][D-1:0]    m_out
);

    always_comb begin
        int unsigned cin, tot, fa_cnt, ha_cnt, src, dst;
        logic [1:0]  cs;
        m_out  = '0;
        cin    = 0;
        tot    = 0;
        fa_cnt = 0;
        ha_cnt = 0;
        src    = 0;
        dst    = 0;
        cs     = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            tot    = 32'(H_IN[i]) + cin;
            fa_cnt = n_fa(tot, D);
            ha_cnt = n_ha(tot, D);
            src    = 0;
            dst    = cin;
            for (int unsigned k = 0; k < fa_cnt; k++) begin
                cs = full_add(m_in[i][src], m_in[i][src+1], m_in[i][src+2]);
                m_out[i][dst] = cs[0];
                if (i + 1 < OUT_W) m_out[i+1][k] = cs[1];
                src += 3;
                dst += 1;
            end
            for (int unsigned k = 0; k < ha_cnt; k++) begin
                cs = half_add(m_in[i][src], m_in[i][src+1]);
                m_out[i][dst] = cs[0];
                if (i + 1 < OUT_W) m_out[i+1][fa_cnt+k] = cs[1];
                src += 2;
                dst += 1;
            end
            for (int unsigned k = src; k < 32'(H_IN[i]); k++) begin
                m_out[i][dst] = m_in[i][k];
                dst += 1;
            end
            cin = fa_cnt + ha_cnt;
        end
    end

endmodule

// File: rtl/dadda_reduce_pipe.sv
// Two-stage pipelined 16x16 Dadda multiplier front end producing sum and carry rows.
// Stage 1 reduces to height 6, stage 2 to height 2; valid/ready on both sides.
module dadda_reduce_pipe
    import dadda_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  row_s,
    output logic [OUT_W-1:0]  row_c
);

    if (N != dadda_pkg::N) begin : g_bad_width
        $error("dadda_reduce_pipe supports only N = 16");
    end
    if (STAGE_SPLIT != DADDA_SEQ[2]) begin : g_bad_split
        $error("STAGE_SPLIT must equal the third Dadda height");
    end

    localparam col_vec_t H0 = pp_heights();
    localparam col_vec_t H1 = layer_out_h(H0, DADDA_SEQ[0]);
    localparam col_vec_t H2 = layer_out_h(H1, DADDA_SEQ[1]);
    localparam col_vec_t H3 = layer_out_h(H2, DADDA_SEQ[2]);
    localparam col_vec_t H4 = layer_out_h(H3, DADDA_SEQ[3]);
    localparam col_vec_t H5 = layer_out_h(H4, DADDA_SEQ[4]);

    logic [OUT_W-1:0][N-1:0]              pp;
    logic [OUT_W-1:0][DADDA_SEQ[0]-1:0]   l1;
    logic [OUT_W-1:0][DADDA_SEQ[1]-1:0]   l2;
    logic [OUT_W-1:0][STAGE_SPLIT-1:0]    l3;
    logic [OUT_W-1:0][DADDA_SEQ[3]-1:0]   l4;
    logic [OUT_W-1:0][DADDA_SEQ[4]-1:0]   l5;
    logic [OUT_W-1:0][1:0]                l6;

    logic [OUT_W-1:0][STAGE_SPLIT-1:0]    s1_m_d, s1_m_q;
    logic                                 v1_d, v1_q, v2_d, v2_q;
    logic [OUT_W-1:0]                     row_s_d, row_s_q, row_c_d, row_c_q;
    logic                                 ready1, ready2;

    // Column i+j is packed from slot 0 upward; above the anti-diagonal slot N-1-j keeps it dense.
    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                pp[i+j][(i + j < N) ? i : N - 1 - j] = a[j] & b[i];
            end
        end
    end

    dadda_layer #(.H_IN(H0), .W_IN(N),            .D(DADDA_SEQ[0])) u_l1 (.m_in(pp), .m_out(l1));
    dadda_layer #(.H_IN(H1), .W_IN(DADDA_SEQ[0]), .D(DADDA_SEQ[1])) u_l2 (.m_in(l1), .m_out(l2));
    dadda_layer #(.H_IN(H2), .W_IN(DADDA_SEQ[1]), .D(STAGE_SPLIT))  u_l3 (.m_in(l2), .m_out(l3));

    dadda_layer #(.H_IN(H3), .W_IN(STAGE_SPLIT),  .D(DADDA_SEQ[3])) u_l4 (.m_in(s1_m_q), .m_out(l4));
    dadda_layer #(.H_IN(H4), .W_IN(DADDA_SEQ[3]), .D(DADDA_SEQ[4])) u_l5 (.m_in(l4), .m_out(l5));
    dadda_layer #(.H_IN(H5), .W_IN(DADDA_SEQ[4]), .D(DADDA_SEQ[5])) u_l6 (.m_in(l5), .m_out(l6));

    always_comb begin
        ready2  = !v2_q || out_ready;
        ready1  = !v1_q || ready2;
        v1_d    = ready1 ? in_valid : v1_q;
        s1_m_d  = ready1 ? l3 : s1_m_q;
        v2_d    = ready2 ? v1_q : v2_q;
        row_s_d = row_s_q;
        row_c_d = row_c_q;
        if (ready2) begin
            for (int unsigned i = 0; i < OUT_W; i++) begin
                row_s_d[i] = l6[i][0];
                row_c_d[i] = l6[i][1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            s1_m_q  <= '0;
            row_s_q <= '0;
            row_c_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            s1_m_q  <= s1_m_d;
            row_s_q <= row_s_d;
            row_c_q <= row_c_d;
        end
    end

    assign in_ready  = ready1;
    assign out_valid = v2_q;
    assign row_s     = row_s_q;
    assign row_c     = row_c_q;

endmodule

// File: tb/tb_dadda_reduce_pipe.sv
// Self-checking bench for dadda_reduce_pipe: directed vector table, reset, backpressure,
// full-rate streaming and random handshake traffic against an in-order scoreboard.
module tb_dadda_reduce_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] row_s;
    logic [31:0] row_c;

    int unsigned n_cmp;
    int unsigned n_bad;
    logic [31:0] exp_q [$];
    logic        stall_prev;
    logic [31:0] held_s, held_c;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [31:0] prod;
    } vec_t;

    vec_t vecs [7];

    dadda_reduce_pipe #(.N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_s     (row_s),
        .row_c     (row_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic monitor();
        logic [31:0] got;
        got = row_s + row_c;
        if (stall_prev) begin
            check("stall_valid_held", 32'(out_valid), 32'd1);
            check("stall_row_s_stable", row_s, held_s);
            check("stall_row_c_stable", row_c, held_c);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_output: got %h, expected no output", got);
            end else begin
                check("sb_sum", got, exp_q.pop_front());
            end
        end
        stall_prev = out_valid && !out_ready;
        held_s     = row_s;
        held_c     = row_c;
    endtask

    task automatic single_op(input int unsigned idx, input vec_t v);
        in_valid  = 1'b1;
        a         = v.va;
        b         = v.vb;
        out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
        next_cycle();
        in_valid = 1'b0;
        #1;
        check($sformatf("vec%0d_valid_early", idx), 32'(out_valid), 32'd0);
        next_cycle();
        #1;
        check($sformatf("vec%0d_valid", idx), 32'(out_valid), 32'd1);
        check($sformatf("vec%0d_sum", idx), row_s + row_c, v.prod);
        next_cycle();
        #1;
        check($sformatf("vec%0d_valid_after", idx), 32'(out_valid), 32'd0);
    endtask

    task automatic run(input int unsigned n, input int unsigned pv, input int unsigned pr,
                       input int unsigned budget, output int unsigned cyc);
        int unsigned sent;
        logic        pending;
        sent       = 0;
        pending    = 1'b0;
        cyc        = 0;
        stall_prev = 1'b0;
        while ((sent < n || exp_q.size() != 0) && cyc < budget) begin
            if (!pending) begin
                if (sent < n && $urandom_range(99) < pv) begin
                    a        = 16'($urandom);
                    b        = 16'($urandom);
                    in_valid = 1'b1;
                    pending  = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(99) < pr);
            #1;
            monitor();
            if (in_valid && in_ready) begin
                exp_q.push_back(32'(a) * 32'(b));
                sent++;
                pending = 1'b0;
            end
            next_cycle();
            cyc++;
        end
        in_valid = 1'b0;
        check("run_all_sent", sent, n);
        check("run_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] bp_a [5];
        logic [15:0] bp_b [5];
        int unsigned idx;
        int unsigned cyc;

        n_cmp      = 0;
        n_bad      = 0;
        stall_prev = 1'b0;
        held_s     = '0;
        held_c     = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b0;

        vecs[0] = '{16'h1234, 16'h5678, 32'h0626_0060};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h0000, 16'hABCD, 32'h0000_0000};
        vecs[3] = '{16'h0001, 16'h8000, 32'h0000_8000};
        vecs[4] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[5] = '{16'hABCD, 16'h0000, 32'h0000_0000};
        vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_row_s", row_s, 32'd0);
        check("rst_row_c", row_c, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors with exact latency
        for (int i = 0; i < 7; i++) single_op(i, vecs[i]);

        // Reset while two items are in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h1111;
        b         = 16'h2222;
        next_cycle();
        a = 16'h3333;
        b = 16'h4444;
        #1;
        check("mid_in_ready_2nd", 32'(in_ready), 32'd1);
        next_cycle();
        #1;
        check("mid_full_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_row_s", row_s, 32'd0);
        check("mid_rst_row_c", row_c, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mid_no_stale", 32'(out_valid), 32'd0);
            next_cycle();
        end

        // Backpressure: five pairs against a stalled sink
        bp_a = '{16'h0001, 16'hFFFF, 16'h1234, 16'h00FF, 16'h8001};
        bp_b = '{16'h0002, 16'hFFFF, 16'h5678, 16'h0100, 16'h7FFF};
        exp_q.delete();
        stall_prev = 1'b0;
        idx        = 0;
        out_ready  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 5);
            if (idx < 5) begin
                a = bp_a[idx];
                b = bp_b[idx];
            end
            #1;
            monitor();
            if (c == 2) begin
                check("bp_in_ready_drop", 32'(in_ready), 32'd0);
                check("bp_accepted", idx, 2);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(32'(a) * 32'(b));
                idx++;
            end
            next_cycle();
        end
        out_ready = 1'b1;
        cyc       = 0;
        while ((idx < 5 || exp_q.size() != 0) && cyc < 30) begin
            in_valid = (idx < 5);
            if (idx < 5) begin
                a = bp_a[idx];
                b = bp_b[idx];
            end
            #1;
            monitor();
            if (in_valid && in_ready) begin
                exp_q.push_back(32'(a) * 32'(b));
                idx++;
            end
            next_cycle();
            cyc++;
        end
        in_valid = 1'b0;
        check("bp_all_sent", idx, 5);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Full-rate streaming: one result per cycle after a two-cycle fill
        run(1000, 100, 100, 5000, cyc);
        check("tput_cycles", cyc, 1002);

        // Random handshake traffic
        run(10000, 50, 50, 60000, cyc);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_no_dup", 32'(out_valid), 32'd0);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dadda_reduce_pipe.md
Name: dadda_reduce_pipe

Overview:
- Pipelined 16x16 unsigned Dadda partial-product generator and reduction tree.
- Accepts operand pairs over a valid/ready handshake and reduces them to two 32-bit rows, a sum row and a carry row.
- Output feeds the final-adder stage directly downstream: two CLA_16b instances cascaded CarryOut->Cin, producing the 32-bit product.
- Two register stages; throughput is one product per cycle when not stalled.

Parameters:
- N, 16, operand width. Only 16 is supported; any other value is a compile-time error.
- OUT_W, 2*N = 32, output row width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage 1 can accept this cycle
- a  in  16  multiplicand, unsigned
- b  in  16  multiplier, unsigned
- out_valid  out  1  rows valid
- out_ready  in  1  downstream final adder accepts
- row_s  out  32  reduced sum row
- row_c  out  32  reduced carry row, already bit-aligned (no further shift)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0, all valid flags are 0. row_s and row_c reset to 0. in_ready reads 1 on the first cycle after release.
- Arithmetic invariant: for every accepted pair, (row_s + row_c) mod 2^32 == a*b. The bench checks this sum, not individual bit patterns. Rows carry no bits above bit 31.
- Partial products: pp[i][j] = a[j] & b[i], weight i+j, 256 bits total.
- Reduction uses the Dadda height sequence 13, 9, 6, 4, 3, 2, built only from full adders (3:2) and half adders (2:2).
- Stage 1 (combinational into reg S1): partial-product generation plus layers to heights 13, 9, 6. S1 holds the height-6 bit matrix and v1.
- Stage 2 (combinational into reg S2): layers to heights 4, 3, 2. S2 holds row_s, row_c and v2.
- Latency: an operand accepted at edge k appears at the outputs after edge k+2, so out_valid=1 in cycle k+2 when there is no stall.
- Handshake on both sides:
  - A transfer occurs when valid & ready are both 1 at a rising edge.
  - in_valid, a and b must be held until accepted. The block holds out_valid, row_s and row_c stable until out_ready=1.
- Ready chain, no combinational path from in_valid to in_ready:
  - ready2 = !v2 | out_ready
  - ready1 = !v1 | ready2
  - in_ready = ready1
- Register updates:
  - S2 loads S1 contents when ready2; v2 <= v1.
  - S1 loads new data when ready1; v1 <= in_valid.
  - When a stage is not ready, it holds its data and valid.
- Full pipeline with out_ready=0: v1=v2=1, in_ready=0, no data lost or overwritten.
- Simultaneous pop and push on a full pipeline: with out_ready=1 the pipeline advances and accepts a new pair in the same cycle, sustaining one per cycle.
- Bubbles: a cycle with in_valid=0 propagates as v1=0. Data registers may update under a bubble, but out_valid=0 then.
- Reset mid-operation: in-flight items are discarded. No output is produced for them after rst_n rises.
- Edge values: a=0 or b=0 gives a row sum of 0. a=b=0xFFFF gives a row sum of 0xFFFE0001.

Decomposition:
- Package dadda_pkg:
  - N, OUT_W
  - the height sequence constant {13, 9, 6, 4, 3, 2}
  - STAGE_SPLIT=6, the height at which S1 registers
  - the per-column bit-count typedef
- One natural sub-module: dadda_layer. It takes an input column-height vector and a target height and instantiates FA/HA cells per column. It is instantiated 6 times, 3 per stage.
- The existing full-adder and half-adder primitives are reused; no new cell types.

Test Plan:
- Reset mid-flight: accept 2 pairs, assert rst_n=0 for 1 cycle -> out_valid=0, rows=0 and in_ready=1 after release; no stale output appears.
- Single op: a=0x1234, b=0x5678, out_ready=1 -> out_valid exactly 2 cycles later; row_s+row_c = 0x06260060.
- Corners: (0xFFFF,0xFFFF) -> 0xFFFE0001; (0,0xABCD) -> 0; (1,0x8000) -> 0x00008000; (0x8000,0x8000) -> 0x40000000.
- Backpressure: stream 5 pairs with out_ready=0 -> in_ready drops after 2 accepted. Release out_ready -> all 5 results emerge in order, each checked, with rows stable while stalled.
- Throughput: 1000 random pairs, in_valid and out_ready held at 1 -> one result per cycle after 2-cycle fill; every row sum matches a*b.
- Random valid/ready toggling, 50% each, 10k pairs -> scoreboard in-order match; no drops or duplicates.
